// File: rtl/sfp_pkg.sv
// Shared constants and word decoder for the SFP telemetry receive path.
// Telemetry words carry {2'b00, sfp_id, 24'h200000, idx, data}.
package sfp_pkg;

  localparam logic [23:0] TLM_TAG      = 24'h200000;
  localparam logic [3:0]  TLM_LAST_IDX = 4'd8;
  localparam int          N_SLV        = 3;

  localparam int ID_LSB  = 60;
  localparam int TAG_LSB = 36;
  localparam int IDX_LSB = 32;

  typedef struct packed {
    logic        is_tlm;
    logic [1:0]  id;
    logic [3:0]  idx;
    logic [31:0] data;
  } tlm_word_t;

  function automatic tlm_word_t tlm_decode(input logic [63:0] w);
    tlm_word_t d;
    d.id     = w[ID_LSB +: 2];
    d.idx    = w[IDX_LSB +: 4];
    d.data   = w[31:0];
    d.is_tlm = (w[63:62] == 2'b00) && (d.id != 2'b00) &&
               (w[TAG_LSB +: 24] == TLM_TAG) && (d.idx <= TLM_LAST_IDX);
    return d;
  endfunction

endpackage

// File: rtl/sfp_tlm_slot.sv
// Per-slave frame reassembly: expected index, staging buffer, shadow registers
// and staleness watchdog. Shadow is only ever written as a whole frame.
module sfp_tlm_slot
  import sfp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_channel_up,
  input  logic        i_wr,
  input  logic [3:0]  i_idx,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_rd_idx,
  output logic [31:0] o_rd_word,
  output logic        o_commit,
  output logic        o_stale,
  output logic        o_err
);

  localparam int              WD_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  logic [3:0]      exp_r;
  logic [31:0]     staging_r [9];
  logic [31:0]     shadow_r  [9];
  logic [WD_W-1:0] wd_r;
  logic            commit_r;
  logic            stale_r;
  logic            in_order_s;

  assign in_order_s = (i_idx == exp_r);
  assign o_err      = i_wr && i_channel_up && !in_order_s;
  assign o_commit   = commit_r;
  assign o_stale    = stale_r;

  // Shadow read: indices past the last word read as zero
  always_comb begin
    o_rd_word = 32'd0;
    if (i_rd_idx <= TLM_LAST_IDX) begin
      o_rd_word = shadow_r[i_rd_idx];
    end else begin
      o_rd_word = 32'd0;
    end
  end

  // Reassembly, atomic commit and watchdog; a commit overrides an expiry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      exp_r    <= 4'd0;
      wd_r     <= '0;
      commit_r <= 1'b0;
      stale_r  <= 1'b1;
      for (int i = 0; i < 9; i++) begin
        staging_r[i] <= 32'd0;
        shadow_r[i]  <= 32'd0;
      end
    end else begin
      commit_r <= 1'b0;
      if (!i_channel_up) begin
        exp_r   <= 4'd0;
        wd_r    <= WD_MAX;
        stale_r <= 1'b1;
      end else begin
        if (wd_r == WD_MAX) begin
          stale_r <= 1'b1;
        end else begin
          wd_r <= wd_r + WD_W'(1);
        end
        if (i_wr) begin
          if (in_order_s) begin
            staging_r[i_idx] <= i_data;
            if (i_idx == TLM_LAST_IDX) begin
              for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= staging_r[i];
              end
              shadow_r[8] <= i_data;
              exp_r    <= 4'd0;
              commit_r <= 1'b1;
              wd_r     <= '0;
              stale_r  <= 1'b0;
            end else begin
              exp_r <= exp_r + 4'd1;
            end
          end else if (i_idx == 4'd0) begin
            // Out-of-order start of frame: resync on it
            staging_r[0] <= i_data;
            exp_r        <= 4'd1;
          end else begin
            exp_r <= 4'd0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sfp_tlm_rx.sv
// Master-side SFP receiver: splits telemetry from response words, feeds the
// per-slave slots, counts sequence errors and serves a registered shadow read.
module sfp_tlm_rx
  import sfp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_channel_up,
  input  logic [63:0] s_rx_sfp_tdata,
  input  logic        s_rx_sfp_tvalid,
  output logic        s_rx_sfp_tready,
  input  logic [1:0]  i_rd_slave,
  input  logic [3:0]  i_rd_idx,
  output logic [31:0] o_rd_data,
  output logic [2:0]  o_frame_done,
  output logic [2:0]  o_stale,
  output logic [15:0] o_seq_err_cnt,
  input  logic        i_clr_err,
  output logic [63:0] o_rsp,
  output logic        o_rsp_valid
);

  tlm_word_t        dec_s;
  logic [N_SLV-1:0] wr_s;
  logic [N_SLV-1:0] err_s;
  logic [31:0]      slot_rd_s [N_SLV];

  assign s_rx_sfp_tready = 1'b1;

  // Field decode of the incoming word
  always_comb begin
    dec_s = tlm_decode(s_rx_sfp_tdata);
  end

  for (genvar g = 0; g < N_SLV; g++) begin : g_slot
    assign wr_s[g] = s_rx_sfp_tvalid && dec_s.is_tlm && (dec_s.id == 2'(g + 1));

    sfp_tlm_slot #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_slot (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_channel_up(i_channel_up),
      .i_wr        (wr_s[g]),
      .i_idx       (dec_s.idx),
      .i_data      (dec_s.data),
      .i_rd_idx    (i_rd_idx),
      .o_rd_word   (slot_rd_s[g]),
      .o_commit    (o_frame_done[g]),
      .o_stale     (o_stale[g]),
      .o_err       (err_s[g])
    );
  end

  // Error counter, response capture and registered read mux
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seq_err_cnt <= 16'd0;
      o_rsp         <= 64'd0;
      o_rsp_valid   <= 1'b0;
      o_rd_data     <= 32'd0;
    end else begin
      if (i_clr_err) begin
        o_seq_err_cnt <= 16'd0;
      end else if ((|err_s) && (o_seq_err_cnt != 16'hFFFF)) begin
        o_seq_err_cnt <= o_seq_err_cnt + 16'd1;
      end else begin
        o_seq_err_cnt <= o_seq_err_cnt;
      end

      if (s_rx_sfp_tvalid && !dec_s.is_tlm) begin
        o_rsp       <= s_rx_sfp_tdata;
        o_rsp_valid <= 1'b1;
      end else begin
        o_rsp_valid <= 1'b0;
      end

      case (i_rd_slave)
        2'd1:    o_rd_data <= slot_rd_s[0];
        2'd2:    o_rd_data <= slot_rd_s[1];
        2'd3:    o_rd_data <= slot_rd_s[2];
        default: o_rd_data <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_tlm_rx.sv
// Directed bench for sfp_tlm_rx with a short watchdog timeout.
module tb_sfp_tlm_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        channel_up;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [1:0]  rd_slave;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic [2:0]  frame_done;
  logic [2:0]  stale;
  logic [15:0] err_cnt;
  logic        clr_err;
  logic [63:0] rsp;
  logic        rsp_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sfp_tlm_rx #(.TIMEOUT_CYC(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_channel_up   (channel_up),
    .s_rx_sfp_tdata (tdata),
    .s_rx_sfp_tvalid(tvalid),
    .s_rx_sfp_tready(tready),
    .i_rd_slave     (rd_slave),
    .i_rd_idx       (rd_idx),
    .o_rd_data      (rd_data),
    .o_frame_done   (frame_done),
    .o_stale        (stale),
    .o_seq_err_cnt  (err_cnt),
    .i_clr_err      (clr_err),
    .o_rsp          (rsp),
    .o_rsp_valid    (rsp_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] id, input logic [3:0] idx,
                                     input logic [31:0] data);
    return {2'b00, id, 24'h200000, idx, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w);
    tdata  = w;
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] s, input logic [3:0] i);
    rd_slave = s;
    rd_idx   = i;
    tick();
  endtask

  initial begin
    rst = 1'b1; channel_up = 1'b1; tdata = 64'd0; tvalid = 1'b0;
    rd_slave = 2'd0; rd_idx = 4'd0; clr_err = 1'b0;
    repeat (3) tick();
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_rsp", rsp, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_stale", 64'(stale), 64'h7);
    check("tready", 64'(tready), 64'd1);
    rst = 1'b0;

    // In-order frame from slave 1
    for (int k = 0; k < 8; k++) send(mk(2'd1, 4'(k), 32'(k)));
    check("s1_no_early_done", 64'(frame_done), 64'd0);
    send(mk(2'd1, 4'd8, 32'd8));
    check("s1_done", 64'(frame_done), 64'h1);
    check("s1_stale", 64'(stale), 64'h6);
    tick();
    check("s1_done_pulse", 64'(frame_done), 64'd0);
    rd(2'd1, 4'd5);
    check("s1_rd5", 64'(rd_data), 64'd5);
    rd(2'd1, 4'd8);
    check("s1_rd8", 64'(rd_data), 64'd8);
    rd(2'd1, 4'd9);
    check("rd_idx9", 64'(rd_data), 64'd0);
    rd(2'd0, 4'd5);
    check("rd_slave0", 64'(rd_data), 64'd0);

    // Slave 2 skips idx 3
    for (int k = 0; k < 3; k++) send(mk(2'd2, 4'(k), 32'h2000_0000 + 32'(k)));
    send(mk(2'd2, 4'd4, 32'h2000_0004));
    check("s2_err", 64'(err_cnt), 64'd1);
    check("s2_no_done", 64'(frame_done), 64'd0);
    rd(2'd2, 4'd0);
    check("s2_uncommitted", 64'(rd_data), 64'd0);
    for (int k = 0; k < 9; k++) send(mk(2'd2, 4'(k), 32'h2000_0000 + 32'(k)));
    check("s2_done", 64'(frame_done), 64'h2);
    check("s2_err_hold", 64'(err_cnt), 64'd1);
    rd(2'd2, 4'd3);
    check("s2_rd3", 64'(rd_data), 64'h2000_0003);

    // Response words, including a tagged word with idx 9
    send(64'h1000_0010_1234_5678);
    check("rsp_word", rsp, 64'h1000_0010_1234_5678);
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    tick();
    check("rsp_valid_pulse", 64'(rsp_valid), 64'd0);
    rd(2'd1, 4'd5);
    check("rsp_no_shadow", 64'(rd_data), 64'd5);
    send(mk(2'd1, 4'd9, 32'hABCD));
    check("rsp_idx9", rsp, mk(2'd1, 4'd9, 32'hABCD));
    check("rsp_idx9_err", 64'(err_cnt), 64'd1);

    // Watchdog
    check("wd_expired", 64'(stale[0]), 64'd1);
    for (int k = 0; k < 9; k++) send(mk(2'd1, 4'(k), 32'h100 + 32'(k)));
    check("wd_commit_clr", 64'(stale[0]), 64'd0);
    repeat (15) tick();
    check("wd_15", 64'(stale[0]), 64'd0);
    tick();
    check("wd_16", 64'(stale[0]), 64'd1);

    // Link drop mid-frame
    for (int k = 0; k < 4; k++) send(mk(2'd1, 4'(k), 32'h300 + 32'(k)));
    channel_up = 1'b0;
    tick();
    check("down_stale", 64'(stale), 64'h7);
    tick();
    channel_up = 1'b1;
    rd(2'd1, 4'd5);
    check("down_shadow_kept", 64'(rd_data), 64'h105);
    for (int k = 4; k < 9; k++) send(mk(2'd1, 4'(k), 32'h300 + 32'(k)));
    check("down_no_done", 64'(frame_done), 64'd0);
    check("down_err", 64'(err_cnt), 64'd6);
    for (int k = 0; k < 9; k++) send(mk(2'd1, 4'(k), 32'h400 + 32'(k)));
    check("down_recommit", 64'(frame_done), 64'h1);
    rd(2'd1, 4'd4);
    check("down_rd4", 64'(rd_data), 64'h404);

    // Interleaved slaves 1 and 3
    for (int k = 0; k < 9; k++) begin
      send(mk(2'd1, 4'(k), 32'h500 + 32'(k)));
      if (k == 8) check("il_s1_done", 64'(frame_done), 64'h1);
      send(mk(2'd3, 4'(k), 32'h700 + 32'(k)));
      if (k == 8) check("il_s3_done", 64'(frame_done), 64'h4);
    end
    check("il_err", 64'(err_cnt), 64'd6);
    rd(2'd3, 4'd7);
    check("il_s3_rd7", 64'(rd_data), 64'h707);
    rd(2'd1, 4'd2);
    check("il_s1_rd2", 64'(rd_data), 64'h502);

    // Read coinciding with commit returns pre-commit value
    rd_slave = 2'd3; rd_idx = 4'd0;
    for (int k = 0; k < 8; k++) send(mk(2'd3, 4'(k), 32'h900 + 32'(k)));
    send(mk(2'd3, 4'd8, 32'h908));
    check("rdc_old", 64'(rd_data), 64'h700);
    check("rdc_done", 64'(frame_done), 64'h4);
    tick();
    check("rdc_new", 64'(rd_data), 64'h900);

    // Error counter saturation and clear priority
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr", 64'(err_cnt), 64'd0);
    tdata  = mk(2'd2, 4'd5, 32'd0);
    tvalid = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    tvalid = 1'b0;
    check("sat", 64'(err_cnt), 64'hFFFF);
    send(mk(2'd2, 4'd5, 32'd0));
    check("sat_hold", 64'(err_cnt), 64'hFFFF);
    clr_err = 1'b1;
    send(mk(2'd2, 4'd5, 32'd0));
    clr_err = 1'b0;
    check("clr_wins", 64'(err_cnt), 64'd0);
    send(mk(2'd2, 4'd5, 32'd0));
    check("after_clr", 64'(err_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
